// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank readout block.
package regbank_pkg;

   localparam int unsigned DEF_WORD_W    = 16;
   localparam int unsigned DEF_NUM_WORDS = 4;

   // Index reported on the checksum beat (one past the last word).
   localparam logic [2:0] CSUM_IDX = 3'(DEF_NUM_WORDS);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      CSUM,
      DONE
   } state_e;

   function automatic logic [2:0] csum_idx(input int unsigned num_words);
      return 3'(num_words);
   endfunction

endpackage

// File: rtl/regbank_next_idx.sv
// Priority search: lowest enabled index at or above from_i, plus flags for
// "nothing left" and "found index is the highest enabled one".
module regbank_next_idx
   import regbank_pkg::*;
#(
   parameter int unsigned NUM_WORDS = DEF_NUM_WORDS
) (
   input  logic [NUM_WORDS-1:0] mask_i,
   input  logic [3:0]           from_i,
   output logic [2:0]           idx_o,
   output logic                 none_o,
   output logic                 last_o
);

   logic found_c;
   logic more_c;

   always_comb begin
      idx_o   = '0;
      found_c = 1'b0;
      more_c  = 1'b0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         if (mask_i[i] && (i >= 32'(from_i))) begin
            if (!found_c) begin
               idx_o   = 3'(i);
               found_c = 1'b1;
            end else begin
               more_c = 1'b1;
            end
         end
      end
      none_o = !found_c;
      last_o = found_c && !more_c;
   end

endmodule

// File: rtl/regbank_reader.sv
// Streams the enabled words of a snapshotted register image over a valid/ready
// port. Optional trailing XOR checksum beat: define REGBANK_READER_CSUM_EN.
module regbank_reader
   import regbank_pkg::*;
#(
   parameter int unsigned WORD_W    = DEF_WORD_W,
   parameter int unsigned NUM_WORDS = DEF_NUM_WORDS
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [NUM_WORDS-1:0]        word_mask,
   input  logic [NUM_WORDS*WORD_W-1:0] data_string,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [WORD_W-1:0]           out_data,
   output logic [2:0]                  out_idx,
   output logic                        out_last,
   output logic                        busy,
   output logic                        done
);

`ifdef REGBANK_READER_CSUM_EN
   localparam bit         CSUM_ON    = 1'b1;
   localparam logic [2:0] CSUM_IDX_P = csum_idx(NUM_WORDS);
   logic [WORD_W-1:0] csum_q;
`else
   localparam bit         CSUM_ON    = 1'b0;
`endif

   state_e                      state_q;
   logic [NUM_WORDS-1:0]        mask_q;
   logic [NUM_WORDS*WORD_W-1:0] data_q;
   logic                        valid_q;
   logic [WORD_W-1:0]           data_o_q;
   logic [2:0]                  idx_q;
   logic                        last_q;
   logic                        busy_q;
   logic                        done_q;

   logic [NUM_WORDS-1:0]        srch_mask;
   logic [NUM_WORDS*WORD_W-1:0] srch_data;
   logic [3:0]                  srch_from;
   logic [2:0]                  nxt_idx;
   logic                        nxt_none;
   logic                        nxt_last;
   logic                        nxt_is_last;
   logic [WORD_W-1:0]           nxt_word;

   // In IDLE the search runs on the live inputs so the first beat can be
   // registered on the same edge that takes the snapshot.
   always_comb begin
      srch_mask = mask_q;
      srch_data = data_q;
      srch_from = 4'(idx_q) + 4'd1;
      if (state_q == IDLE) begin
         srch_mask = word_mask;
         srch_data = data_string;
         srch_from = '0;
      end
      nxt_word = '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         if (nxt_idx == 3'(i)) nxt_word = srch_data[i*WORD_W +: WORD_W];
      end
      nxt_is_last = nxt_last && !CSUM_ON;
   end

   regbank_next_idx #(
      .NUM_WORDS (NUM_WORDS)
   ) u_next_idx (
      .mask_i (srch_mask),
      .from_i (srch_from),
      .idx_o  (nxt_idx),
      .none_o (nxt_none),
      .last_o (nxt_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         data_o_q <= '0;
         idx_q    <= '0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef REGBANK_READER_CSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  mask_q <= word_mask;
                  data_q <= data_string;
                  busy_q <= 1'b1;
`ifdef REGBANK_READER_CSUM_EN
                  csum_q <= '0;
`endif
                  if (!nxt_none) begin
                     state_q  <= SEND;
                     valid_q  <= 1'b1;
                     data_o_q <= nxt_word;
                     idx_q    <= nxt_idx;
                     last_q   <= nxt_is_last;
                  end else begin
`ifdef REGBANK_READER_CSUM_EN
                     state_q  <= CSUM;
                     valid_q  <= 1'b1;
                     data_o_q <= '0;
                     idx_q    <= CSUM_IDX_P;
                     last_q   <= 1'b1;
`else
                     state_q  <= DONE;
                     done_q   <= 1'b1;
`endif
                  end
               end
            end
            SEND: begin
               if (out_ready) begin
`ifdef REGBANK_READER_CSUM_EN
                  csum_q <= csum_q ^ data_o_q;
`endif
                  if (!nxt_none) begin
                     data_o_q <= nxt_word;
                     idx_q    <= nxt_idx;
                     last_q   <= nxt_is_last;
                  end else begin
`ifdef REGBANK_READER_CSUM_EN
                     state_q  <= CSUM;
                     data_o_q <= csum_q ^ data_o_q;
                     idx_q    <= CSUM_IDX_P;
                     last_q   <= 1'b1;
`else
                     state_q  <= DONE;
                     valid_q  <= 1'b0;
                     data_o_q <= '0;
                     idx_q    <= '0;
                     last_q   <= 1'b0;
                     done_q   <= 1'b1;
`endif
                  end
               end
            end
`ifdef REGBANK_READER_CSUM_EN
            CSUM: begin
               if (out_ready) begin
                  state_q  <= DONE;
                  valid_q  <= 1'b0;
                  data_o_q <= '0;
                  idx_q    <= '0;
                  last_q   <= 1'b0;
                  done_q   <= 1'b1;
               end
            end
`endif
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_o_q;
   assign out_idx   = idx_q;
   assign out_last  = last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_regbank_reader.sv
// Scoreboard bench for regbank_reader: a list-level model queues the expected
// beats and done pulse; a negedge monitor checks the DUT against the queue.
module tb_regbank_reader;

   localparam int NW = 4;
   localparam int W  = 16;
`ifdef REGBANK_READER_CSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   typedef struct {
      bit          is_done;
      logic [15:0] data;
      logic [2:0]  idx;
      bit          last;
      int          cyc;
   } exp_t;

   logic            clk;
   logic            reset;
   logic            start;
   logic [NW-1:0]   word_mask;
   logic [NW*W-1:0] data_string;
   logic            out_ready;
   logic            out_valid;
   logic [W-1:0]    out_data;
   logic [2:0]      out_idx;
   logic            out_last;
   logic            busy;
   logic            done;

   exp_t q[$];
   int   checks    = 0;
   int   failures  = 0;
   int   cyc       = 0;
   int   start_cyc = 0;
   int   ready_mode = 0;
   bit   forced_ready = 1'b1;

   regbank_reader #(
      .WORD_W    (W),
      .NUM_WORDS (NW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .word_mask   (word_mask),
      .data_string (data_string),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_idx     (out_idx),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ready: 0 = always high, 1 = toggle, 2 = random, 3 = follow forced_ready
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = forced_ready;
         endcase
      end
   end

   // Expected readout from the mask/image: enabled words in ascending order,
   // optional XOR beat, then the done pulse.
   function automatic void model_push(input logic [3:0] m, input logic [63:0] d, input bit timed);
      exp_t        e;
      int          n  = 0;
      int          hi = -1;
      logic [15:0] x  = '0;
      for (int i = 0; i < NW; i++) if (m[i]) hi = i;
      for (int i = 0; i < NW; i++) begin
         if (m[i]) begin
            n++;
            e.is_done = 1'b0;
            e.data    = d[i*W +: W];
            e.idx     = 3'(i);
            e.last    = (i == hi) && !CSUM_EN;
            e.cyc     = timed ? n : -1;
            x         = x ^ e.data;
            q.push_back(e);
         end
      end
      if (CSUM_EN) begin
         n++;
         e.is_done = 1'b0;
         e.data    = x;
         e.idx     = 3'(NW);
         e.last    = 1'b1;
         e.cyc     = timed ? n : -1;
         q.push_back(e);
      end
      e.is_done = 1'b1;
      e.data    = '0;
      e.idx     = '0;
      e.last    = 1'b0;
      e.cyc     = timed ? n + 1 : -1;
      q.push_back(e);
   endfunction

   always @(negedge clk) begin
      bit have, exp_valid, exp_done;
      if (!reset) begin
         have      = q.size() > 0;
         exp_valid = have && !q[0].is_done;
         exp_done  = have && q[0].is_done;
         chk("valid", 32'(out_valid), 32'(exp_valid));
         chk("done", 32'(done), 32'(exp_done));
         chk("busy", 32'(busy), 32'(have));
         if (!out_valid) chk("data_zero_when_invalid", 32'(out_data), 32'h0);
         if (exp_valid && out_valid) begin
            chk("beat_data", 32'(out_data), 32'(q[0].data));
            chk("beat_idx", 32'(out_idx), 32'(q[0].idx));
            chk("beat_last", 32'(out_last), 32'(q[0].last));
            if (q[0].cyc >= 0) chk("beat_cycle", 32'(cyc - start_cyc), 32'(q[0].cyc));
            if (out_ready) void'(q.pop_front());
         end else if (exp_done && done) begin
            if (q[0].cyc >= 0) chk("done_cycle", 32'(cyc - start_cyc), 32'(q[0].cyc));
            void'(q.pop_front());
         end
      end
   end

   task automatic start_read(input logic [3:0] m, input logic [63:0] d, input int mode);
      @(posedge clk);
      #1;
      ready_mode  = mode;
      start       = 1'b1;
      word_mask   = m;
      data_string = d;
      start_cyc   = cyc;
      @(posedge clk);
      model_push(m, d, mode == 0);
      #1;
      start = 1'b0;
   endtask

   // Runs until the scoreboard drains; with noise, keeps scrambling the
   // inputs and re-pulsing start, all of which must be ignored.
   task automatic finish_read(input bit noise);
      bit drained = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (q.size() == 0) begin
            drained = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         if (q.size() == 0) begin
            drained = 1'b1;
            break;
         end
         if (noise) begin
            start       = ($urandom_range(0, 2) == 0);
            data_string = {$urandom, $urandom};
            word_mask   = 4'($urandom);
         end
      end
      start = 1'b0;
      if (!drained) begin
         checks++;
         failures++;
         $display("FAIL readout_timeout pending=%0d expected=0", q.size());
         q.delete();
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_data"}, 32'(out_data), 32'h0);
      chk({tag, "_idx"}, 32'(out_idx), 32'h0);
      chk({tag, "_last"}, 32'(out_last), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_done"}, 32'(done), 32'h0);
   endtask

   initial begin
      logic [63:0] img;
      reset       = 1'b1;
      start       = 1'b0;
      word_mask   = '0;
      data_string = '0;
      img         = 64'h4444_3333_2222_1111;
      repeat (3) @(posedge clk);
      #2;
      chk_outputs_zero("reset_state");
      reset = 1'b0;

      start_read(4'b1111, img, 0);
      finish_read(1'b0);
      start_read(4'b1010, img, 1);
      finish_read(1'b0);
      start_read(4'b0000, img, 0);
      finish_read(1'b0);
      start_read(4'b1111, img, 0);
      finish_read(1'b1);
      start_read(4'b0110, 64'hDEAD_BEEF_0123_4567, 2);
      finish_read(1'b1);

      // Abort while the third beat is stalled.
      forced_ready = 1'b1;
      start_read(4'b1111, img, 3);
      @(posedge clk);
      @(posedge clk);
      forced_ready = 1'b0;
      @(posedge clk);
      #3;
      reset = 1'b1;
      q.delete();
      #1;
      chk_outputs_zero("reset_abort");
      @(posedge clk);
      #2;
      reset        = 1'b0;
      forced_ready = 1'b1;
      #1;
      chk_outputs_zero("after_abort");
      start_read(4'b1111, img, 0);
      finish_read(1'b0);

      for (int r = 0; r < 24; r++) begin
         start_read(4'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 2)));
         finish_read(1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout time=%0t limit=2000000", $time);
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/regbank_reader.md
REGBANK_READER -- requirements
Module: regbank_reader

Interface
REQ-001 Parameter WORD_W, default 16, width of one register word.
REQ-002 Parameter NUM_WORDS, default 4, number of words in the packed register image.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to read out the register image; sampled only in IDLE.
REQ-006 word_mask  input  NUM_WORDS  per-word enable; bit i=1 sends word i; sampled with start.
REQ-007 data_string  input  NUM_WORDS*WORD_W  packed register image; word i at bits [i*WORD_W +: WORD_W].
REQ-008 out_ready  input  1  downstream ready.
REQ-009 out_valid  output  1  out_data/out_idx/out_last valid.
REQ-010 out_data  output  WORD_W  current word.
REQ-011 out_idx  output  3  index of current word (0..NUM_WORDS-1; NUM_WORDS for checksum).
REQ-012 out_last  output  1  current beat is final beat of the readout.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after readout completes.

Function
REQ-015 FSM states SHALL be IDLE, SEND, CSUM, DONE.
REQ-016 IDLE: on start=1, data_string and word_mask SHALL be snapshotted into internal registers in that same edge; next state SEND, or DONE if the mask is zero and checksum is compiled out.
REQ-017 With a nonzero mask, out_valid SHALL assert exactly one cycle after the start cycle, presenting the lowest-index enabled word.
REQ-018 A beat SHALL transfer on any rising edge with out_valid=1 and out_ready=1; the next enabled word SHALL be presented the following cycle with no bubble.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-020 Words with mask bit 0 SHALL be skipped without consuming cycles; ascending index order only.
REQ-021 out_last SHALL be 1 on the highest-index enabled word (checksum compiled out) or on the checksum beat (compiled in).
REQ-022 After the transfer of the out_last beat, state DONE SHALL last one cycle with done=1, out_valid=0, then return to IDLE.
REQ-023 start asserted while busy=1 SHALL be ignored; start in the DONE cycle is ignored.
REQ-024 Changes on data_string or word_mask after the snapshot SHALL NOT affect the readout in progress.
REQ-025 out_valid SHALL be 0 in IDLE and DONE; out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-026 reset=1 SHALL force IDLE immediately, aborting any readout without a done pulse.
REQ-027 Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, snapshot and checksum registers 0.

Configuration
REQ-028 Macro REGBANK_READER_CSUM_EN defined: after the last enabled word, state CSUM SHALL present one extra beat with out_idx=NUM_WORDS and out_data = XOR of all transferred words (0 if mask zero); a zero mask goes SEND-free directly to CSUM.
REQ-029 Macro undefined: CSUM state and checksum register SHALL be absent; out_idx never exceeds NUM_WORDS-1.

Structure
REQ-030 Package regbank_pkg SHALL hold the FSM state enum, WORD_W/NUM_WORDS defaults and the CSUM index constant.
REQ-031 Sub-module regbank_next_idx SHALL compute the next enabled index at or above a given index from the snapshot mask (combinational priority search), plus a none-left flag.

Verification
REQ-032 Mask 4'b1111, data_string 64'h4444_3333_2222_1111, ready=1 -> beats 1111,2222,3333,4444 idx 0..3 on cycles 1..4 after start, last on 4444, done on cycle 5.
REQ-033 Mask 4'b1010, ready toggling 0/1 each cycle -> beats 2222(idx1), 4444(idx3, last); data stable through stalls.
REQ-034 Mask 4'b0000, CSUM disabled -> no valid, done=1 one cycle after start; CSUM enabled -> single beat idx 4 data 0 last, then done.
REQ-035 CSUM enabled, mask 4'b1111, same data -> fifth beat idx 4 data 16'h4444 (XOR of the four words), last=1.
REQ-036 data_string changed and start re-pulsed during readout -> original snapshot words sent, second start ignored, exactly one done.
REQ-037 reset asserted during third beat stalled -> outputs zero immediately, busy=0, no done; fresh start afterwards reads out normally.
